// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one external 8-bit ALU between two requesters.
// Each operation is registered, evaluated for one cycle, then held until the owner takes it.
module alu_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic              req1_cin,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_ovf,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_ovf,
  output logic [DATA_W-1:0] alu_input_1,
  output logic [DATA_W-1:0] alu_input_2,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow_flag,
  input  logic              alu_zero_flag,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q;
  logic              grant0, grant1, accept, done;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zero_q, res_ovf_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant0  = req0_valid & (~req1_valid | ~prio_q);
    grant1  = req1_valid & (~req0_valid | prio_q);
    accept  = (state_q == IDLE) & (grant0 | grant1);
    done    = (state_q == RESP) & (owner ? rsp1_ready : rsp0_ready);
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked during reset so nothing looks accepted on a cycle that is being discarded.
  assign req0_ready = (state_q == IDLE) & grant0 & ~rst;
  assign req1_ready = (state_q == IDLE) & grant1 & ~rst;

  assign rsp0_valid = (state_q == RESP) & ~owner;
  assign rsp1_valid = (state_q == RESP) & owner;
  assign rsp0_data  = res_data_q;
  assign rsp1_data  = res_data_q;
  assign rsp0_zero  = res_zero_q;
  assign rsp1_zero  = res_zero_q;
  assign rsp0_ovf   = res_ovf_q;
  assign rsp1_ovf   = res_ovf_q;
  assign busy       = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, including operands and results.
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner       <= 1'b0;
      alu_input_1 <= '0;
      alu_input_2 <= '0;
      alu_sel     <= '0;
      alu_cin     <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      done_cnt0   <= '0;
      done_cnt1   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner       <= grant1;
        alu_input_1 <= grant1 ? req1_a   : req0_a;
        alu_input_2 <= grant1 ? req1_b   : req0_b;
        alu_sel     <= grant1 ? req1_sel : req0_sel;
        alu_cin     <= grant1 ? req1_cin : req0_cin;
      end
      if (state_q == EXEC) begin
        res_data_q <= alu_out;
        res_zero_q <= alu_zero_flag;
        res_ovf_q  <= alu_overflow_flag;
      end
      if (done) begin
        prio_q <= ~owner;
        if (owner) done_cnt1 <= done_cnt1 + CNT_W'(1);
        else       done_cnt0 <= done_cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a behavioural ALU stands in for the shared unit,
// stimulus pushes hand-computed responses into a scoreboard that a monitor drains.
module tb_alu_rr_scheduler;

  logic       clk, rst;
  logic       req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp0_zero, rsp0_ovf;
  logic       rsp1_valid, rsp1_ready, rsp1_zero, rsp1_ovf;
  logic [7:0] rsp0_data, rsp1_data;
  logic [7:0] alu_input_1, alu_input_2, alu_out;
  logic [2:0] alu_sel;
  logic       alu_cin, alu_overflow_flag, alu_zero_flag;
  logic       busy, owner;
  logic [7:0] done_cnt0, done_cnt1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_ovf(rsp0_ovf),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_ovf(rsp1_ovf),
    .alu_input_1(alu_input_1), .alu_input_2(alu_input_2), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_overflow_flag(alu_overflow_flag), .alu_zero_flag(alu_zero_flag),
    .busy(busy), .owner(owner), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared ALU: signed overflow on add/sub, zero result for 11x.
  always_comb begin
    alu_out           = 8'h00;
    alu_overflow_flag = 1'b0;
    case (alu_sel)
      3'b000: begin
        alu_out           = alu_input_1 + alu_input_2 + {7'd0, alu_cin};
        alu_overflow_flag = (alu_input_1[7] == alu_input_2[7]) && (alu_out[7] != alu_input_1[7]);
      end
      3'b001: begin
        alu_out           = alu_input_1 - alu_input_2;
        alu_overflow_flag = (alu_input_1[7] != alu_input_2[7]) && (alu_out[7] != alu_input_1[7]);
      end
      3'b010:  alu_out = alu_input_1 & alu_input_2;
      3'b011:  alu_out = alu_input_1 | alu_input_2;
      3'b100:  alu_out = alu_input_1 ^ alu_input_2;
      3'b101:  alu_out = alu_input_1 ~^ alu_input_2;
      default: alu_out = 8'h00;
    endcase
    alu_zero_flag = (alu_out == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected response per completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid || rsp1_valid) check("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_id", 32'(rsp1_valid), 32'(mon_e.id));
          if (rsp1_valid) check("rsp1_payload", {rsp1_data, rsp1_zero, rsp1_ovf}, {mon_e.data, mon_e.zero, mon_e.ovf});
          else            check("rsp0_payload", {rsp0_data, rsp0_zero, rsp0_ovf}, {mon_e.data, mon_e.zero, mon_e.ovf});
        end
      end
    end
  end

  task automatic push_exp(input logic id, input logic [7:0] d, input logic z, input logic o);
    sb.push_back('{id: id, data: d, zero: z, ovf: o});
  endtask

  task automatic drive(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sel, input logic cin);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin;
    end
  endtask

  task automatic wait_ready(input logic id);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(id ? "req1_ready_wait" : "req0_ready_wait", 32'(id ? req1_ready : req0_ready), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy), 0);
  endtask

  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input logic cin, input logic [7:0] ed, input logic ez, input logic eo);
    @(posedge clk); #1;
    push_exp(id, ed, ez, eo);
    drive(id, 1'b1, a, b, sel, cin);
    wait_ready(id);
    @(posedge clk); #1;
    drive(id, 1'b0, a, b, sel, cin);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int last_cyc;
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_cnts", {done_cnt0, done_cnt1}, 0);
    check("rst_alu_regs", {alu_input_1, alu_input_2, alu_sel, alu_cin}, 0);
    check("rst_valids", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);

    // Latency: accept in cycle T, response valid from T+2.
    @(posedge clk); #1;
    push_exp(0, 8'h08, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h05, 8'h03, 3'b000, 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    check("lat_t1_rsp0_valid", 32'(rsp0_valid), 0);
    @(negedge clk);
    check("lat_t2_rsp0_valid", 32'(rsp0_valid), 1);
    @(negedge clk);
    check("lat_done_cnt0", 32'(done_cnt0), 1);

    // Simultaneous requests after reset: req0 first, then req1.
    apply_reset();
    push_exp(0, 8'h00, 1'b1, 1'b0);
    push_exp(1, 8'hFF, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h10, 8'h10, 3'b001, 1'b0);
    drive(1, 1'b1, 8'h0F, 8'hF0, 3'b011, 1'b0);
    wait_ready(0);
    check("pair_req1_blocked", 32'(req1_ready), 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_ready(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_idle();
    check("pair_cnts", {done_cnt0, done_cnt1}, {8'd1, 8'd1});

    // Continuous contention: grants alternate, one idle cycle between operations.
    apply_reset();
    drive(0, 1'b1, 8'h01, 8'h02, 3'b000, 1'b1);
    drive(1, 1'b1, 8'h3C, 8'h0F, 3'b010, 1'b0);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      if (k % 2 == 0) push_exp(0, 8'h04, 1'b0, 1'b0);
      else            push_exp(1, 8'h0C, 1'b0, 1'b0);
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("rr_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
      check("rr_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
      check("rr_busy_low", 32'(busy), 0);
      if (k > 0) check("rr_period", cyc - last_cyc, 3);
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_idle();
    check("rr_cnts", {done_cnt0, done_cnt1}, {8'd2, 8'd2});

    // Response backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 1'b0;
    @(posedge clk); #1;
    push_exp(0, 8'hF0, 1'b0, 1'b0);
    push_exp(1, 8'h00, 1'b1, 1'b0);
    drive(0, 1'b1, 8'h0F, 8'hFF, 3'b100, 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    drive(1, 1'b1, 8'h0F, 8'hF0, 3'b101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp0_valid", 32'(rsp0_valid), 1);
      check("bp_rsp0_payload", {rsp0_data, rsp0_zero, rsp0_ovf}, {8'hF0, 1'b0, 1'b0});
      check("bp_req_ready", {req0_ready, req1_ready}, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_cnt0_before", 32'(done_cnt0), 2);
    @(negedge clk);
    check("bp_cnt0_after", 32'(done_cnt0), 3);
    check("bp_rsp0_dropped", 32'(rsp0_valid), 0);
    check("bp_req1_granted", 32'(req1_ready), 1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_idle();

    // Signed overflow cases.
    do_op(1, 8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(0, 8'h80, 8'h01, 3'b001, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_idle();

    // Reset during EXEC of a req1 xor discards it.
    @(posedge clk); #1;
    drive(1, 1'b1, 8'h12, 8'h34, 3'b100, 1'b0);
    wait_ready(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valids", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    check("mid_rst_state", {busy, owner}, 0);
    check("mid_rst_alu_regs", {alu_input_1, alu_input_2, alu_sel, alu_cin}, 0);
    check("mid_rst_result", {rsp1_data, rsp1_zero, rsp1_ovf}, 0);
    check("mid_rst_cnts", {done_cnt0, done_cnt1}, 0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_rsp1", 32'(rsp1_valid), 0);
    end

    // Priority back at 0: req0 zero-opcode wins over req1.
    @(posedge clk); #1;
    push_exp(0, 8'h00, 1'b1, 1'b0);
    push_exp(1, 8'hFF, 1'b0, 1'b0);
    drive(0, 1'b1, 8'hAA, 8'h55, 3'b110, 1'b0);
    drive(1, 1'b1, 8'hAA, 8'h55, 3'b011, 1'b0);
    wait_ready(0);
    check("prio0_req1_blocked", 32'(req1_ready), 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_ready(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    wait_idle();
    check("zero_op_cnt0", 32'(done_cnt0), 1);

    // 255 more completions wrap the counter to 0.
    for (int i = 0; i < 255; i++) do_op(0, 8'hAA, 8'h55, 3'b111, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_idle();
    check("wrap_cnt0", 32'(done_cnt0), 0);
    check("wrap_cnt1", 32'(done_cnt1), 1);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 8-bit combinational ALU instance between two requesters (req0, req1) using round-robin arbitration.
- Each requester has a valid/ready operation channel and a valid/ready response channel.
- The block registers the winning operands, drives them to the ALU, captures the result and flags, and returns them to the owning requester.
- It sits between the two client blocks and the ALU. It also keeps per-requester completion counters.

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU width (8).
- SEL_W, 3, ALU opcode width.
- CNT_W, 8, completion counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  DATA_W  operand 1
- req0_b  input  DATA_W  operand 2
- req0_sel  input  SEL_W  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 xnor, 11x zero
- req0_cin  input  1  carry-in for add
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_cin  same as req0, for requester 1
- rsp0_valid  output  1  response for requester 0 available
- rsp0_ready  input  1  requester 0 takes response
- rsp0_data  output  DATA_W  ALU result
- rsp0_zero  output  1  ALU zero flag
- rsp0_ovf  output  1  ALU overflow flag
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero, rsp1_ovf  same as rsp0, for requester 1
- alu_input_1  output  DATA_W  registered operand 1 to ALU
- alu_input_2  output  DATA_W  registered operand 2 to ALU
- alu_sel  output  SEL_W  registered opcode to ALU
- alu_cin  output  1  registered carry-in to ALU
- alu_out  input  DATA_W  ALU result
- alu_overflow_flag  input  1  ALU overflow flag
- alu_zero_flag  input  1  ALU zero flag
- busy  output  1  state != IDLE
- owner  output  1  requester currently served (last served when IDLE)
- done_cnt0  output  CNT_W  completed responses for requester 0
- done_cnt1  output  CNT_W  completed responses for requester 1

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state=IDLE, prio=0, owner=0.
  - Operand, opcode, cin and result/flag registers all 0.
  - done_cnt0/1=0.
  - All valid/ready outputs 0 the next cycle.
- Reset mid-operation: the in-flight operation is discarded. No response is issued and no counter increments.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant selection (combinational from the valids):
  - Only one valid: grant that requester.
  - Both valid: grant the requester indicated by prio.
  - Neither valid: stay in IDLE.
- IDLE, accept:
  - reqN_ready = (state==IDLE) & grantN; at most one ready is high per cycle.
  - On accept: latch a/b/sel/cin into the alu_* registers, set owner=N, go to EXEC.
- EXEC (one cycle):
  - The ALU evaluates the registered operands.
  - At the end of the cycle, alu_out/alu_zero_flag/alu_overflow_flag are captured into the result registers; go to RESP.
- RESP:
  - rspN_valid=1 for N==owner only. rspN_data/zero/ovf come from the result registers and are stable while valid is held.
  - On rspN_ready=1: increment done_cntN (wraps modulo 2^CNT_W), set prio=~owner, go to IDLE.
  - rspN_ready is ignored while rspN_valid=0.
- Latency and throughput:
  - Accept edge at cycle T -> rsp_valid high from cycle T+2.
  - Minimum 3 cycles per operation; no overlap. req_ready stays 0 in EXEC/RESP regardless of backpressure duration.
- The opcode is forwarded unmodified. For 110/111 the response is data=0x00, zero=1, ovf=0, as produced by the ALU.
- Operand inputs are don't-care while the matching valid is 0. A requester may drop valid without being accepted; nothing is latched.
- alu_* outputs hold their last values in IDLE and RESP.

Test Plan:
- Reset, then req0 add a=0x05 b=0x03 cin=0 -> req0_ready pulse in cycle T; rsp0_valid from T+2; data=0x08, zero=0, ovf=0; done_cnt0=1 after rsp0_ready.
- After reset, req0 and req1 both valid in the same cycle (req0 sub 0x10-0x10, req1 or 0x0F|0xF0) -> req0 served first (data=0x00, zero=1), then req1 (data=0xFF, zero=0); rsp1 never valid during req0's response.
- Both requesters continuously valid for 4 operations -> grants alternate 0,1,0,1; done_cnt0=2, done_cnt1=2; busy low exactly one cycle between operations.
- rsp0_ready held low for 5 cycles in RESP -> rsp0_valid, rsp0_data and flags stable; req0_ready and req1_ready stay 0; completion occurs on the first cycle rsp0_ready=1.
- rst asserted during EXEC of a req1 xor -> no rsp1_valid; done_cnt1=0; state IDLE; all outputs 0 the following cycle; prio=0.
- req0 sel=3'b110 with a=0xAA b=0x55 -> rsp0_data=0x00, zero=1, ovf=0; done_cnt0 increments; 256 completions wrap done_cnt0 to 0.
